// File: rtl/sat_engine_pkg.sv
// Shared defaults and FSM state encoding for the conflict-analysis / backtrack controller.
package sat_engine_pkg;

  localparam int DEF_NUM_VARS    = 8;
  localparam int DEF_WIDTH_LVL   = 10;
  localparam int DEF_WIDTH_C_LEN = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ANALYZE = 3'd1,
    SCAN    = 3'd2,
    BKT     = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/analyze_bkt_ctrl_if.sv
// Request/response bundle between the variable bin (master) and analyze_bkt_ctrl (slave).
interface analyze_bkt_ctrl_if
  import sat_engine_pkg::*;
#(
  parameter int NUM_VARS    = DEF_NUM_VARS,
  parameter int WIDTH_LVL   = DEF_WIDTH_LVL,
  parameter int WIDTH_C_LEN = DEF_WIDTH_C_LEN
);

  logic                          start_i;
  logic [NUM_VARS-1:0]           find_conflict_i;
  logic [NUM_VARS-1:0]           clause_len_i;
  logic [NUM_VARS*WIDTH_LVL-1:0] max_lvl_i;
  logic                          apply_analyze_o;
  logic                          apply_bkt_o;
  logic [WIDTH_LVL-1:0]          bkt_lvl_o;
  logic [WIDTH_C_LEN-1:0]        learnt_len_o;
  logic                          done_o;
  logic                          unsat_o;

  modport master (
    output start_i, find_conflict_i, clause_len_i, max_lvl_i,
    input  apply_analyze_o, apply_bkt_o, bkt_lvl_o, learnt_len_o, done_o, unsat_o
  );

  modport slave (
    input  start_i, find_conflict_i, clause_len_i, max_lvl_i,
    output apply_analyze_o, apply_bkt_o, bkt_lvl_o, learnt_len_o, done_o, unsat_o
  );

endinterface

// File: rtl/max2_tracker.sv
// Registered tracker of the highest and second-highest distinct level seen since the last clear.
module max2_tracker
  import sat_engine_pkg::*;
#(
  parameter int WIDTH_LVL = DEF_WIDTH_LVL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [WIDTH_LVL-1:0] lvl,
  output logic [WIDTH_LVL-1:0] max_nxt_o,
  output logic [WIDTH_LVL-1:0] sec_nxt_o
);

  logic [WIDTH_LVL-1:0] max_q;
  logic [WIDTH_LVL-1:0] sec_q;
  logic [WIDTH_LVL-1:0] max_nxt;
  logic [WIDTH_LVL-1:0] sec_nxt;

  // Second must stay strictly below max, so a repeat of either level is a no-op.
  always_comb begin
    max_nxt = max_q;
    sec_nxt = sec_q;
    if (en) begin
      if (lvl > max_q) begin
        max_nxt = lvl;
        sec_nxt = max_q;
      end else if ((lvl < max_q) && (lvl > sec_q)) begin
        sec_nxt = lvl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      max_q <= '0;
      sec_q <= '0;
    end else if (clr) begin
      max_q <= '0;
      sec_q <= '0;
    end else begin
      max_q <= max_nxt;
      sec_q <= sec_nxt;
    end
  end

  assign max_nxt_o = max_nxt;
  assign sec_nxt_o = sec_nxt;

endmodule

// File: rtl/analyze_bkt_ctrl.sv
// Conflict-analysis / backtrack sequencer for one variable bin.
// Optional ANALYZE watchdog enabled by defining ANALYZE_TIMEOUT_EN.
module analyze_bkt_ctrl
  import sat_engine_pkg::*;
#(
  parameter int NUM_VARS    = DEF_NUM_VARS,
  parameter int WIDTH_LVL   = DEF_WIDTH_LVL,
  parameter int WIDTH_C_LEN = DEF_WIDTH_C_LEN
) (
  input logic               clk,
  input logic               rst,
  analyze_bkt_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;

  function automatic logic [WIDTH_C_LEN-1:0] sat_inc(input logic [WIDTH_C_LEN-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                 state_q, state_nxt;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_VARS-1:0]    fc_q;
  logic                   an_seen_q;
  logic [WIDTH_C_LEN-1:0] len_q, len_nxt;
  logic [WIDTH_LVL-1:0]   bkt_lvl_q;
  logic [WIDTH_C_LEN-1:0] learnt_q;
  logic                   unsat_q;

  logic                   accept;
  logic                   scan_last;
  logic                   an_stable;
  logic                   an_timeout;
  logic                   unsat_cond;
  logic                   cur_flag;
  logic [WIDTH_LVL-1:0]   cur_lvl;
  logic [WIDTH_LVL-1:0]   max_nxt;
  logic [WIDTH_LVL-1:0]   sec_nxt;

  assign accept    = (state_q == IDLE) && bus.start_i;
  assign scan_last = (state_q == SCAN) && (idx_q == IDX_W'(NUM_VARS - 1));
  // an_seen_q marks that fc_q already holds a value captured inside this ANALYZE visit.
  assign an_stable = (state_q == ANALYZE) && an_seen_q && (bus.find_conflict_i == fc_q);

`ifdef ANALYZE_TIMEOUT_EN
  localparam int TO_W = $clog2(2 * NUM_VARS);
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt_q <= '0;
    end else if (state_q == ANALYZE) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign an_timeout = (state_q == ANALYZE) && (to_cnt_q == TO_W'(2 * NUM_VARS - 1));
`else
  assign an_timeout = 1'b0;
`endif

  always_comb begin
    cur_flag = 1'b0;
    cur_lvl  = '0;
    for (int k = 0; k < NUM_VARS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_flag = bus.clause_len_i[k];
        cur_lvl  = bus.max_lvl_i[k*WIDTH_LVL +: WIDTH_LVL];
      end
    end
  end

  assign len_nxt = ((state_q == SCAN) && cur_flag) ? sat_inc(len_q) : len_q;

  max2_tracker #(.WIDTH_LVL(WIDTH_LVL)) u_max2 (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .en        ((state_q == SCAN) && cur_flag),
    .lvl       (cur_lvl),
    .max_nxt_o (max_nxt),
    .sec_nxt_o (sec_nxt)
  );

  // Decision uses the post-update values so the last variable counts without an extra cycle.
  assign unsat_cond = (len_nxt == '0) || (max_nxt == '0);

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_nxt = ANALYZE;
      ANALYZE: if (an_stable || an_timeout) state_nxt = SCAN;
      SCAN:    if (scan_last) state_nxt = unsat_cond ? DONE : BKT;
      BKT:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      fc_q      <= '0;
      an_seen_q <= 1'b0;
      len_q     <= '0;
      bkt_lvl_q <= '0;
      learnt_q  <= '0;
      unsat_q   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      an_seen_q <= (state_q == ANALYZE);
      unsat_q   <= scan_last && unsat_cond;
      idx_q     <= ((state_q == SCAN) && !scan_last) ? idx_q + 1'b1 : '0;
      if (state_q == ANALYZE) fc_q <= bus.find_conflict_i;
      if (accept) begin
        len_q     <= '0;
        bkt_lvl_q <= '0;
        learnt_q  <= '0;
      end else begin
        if (state_q == SCAN) len_q <= len_nxt;
        if (scan_last && !unsat_cond) begin
          bkt_lvl_q <= sec_nxt;
          learnt_q  <= len_nxt;
        end
      end
    end
  end

  assign bus.apply_analyze_o = (state_q == ANALYZE) || (state_q == SCAN);
  assign bus.apply_bkt_o     = (state_q == BKT);
  assign bus.done_o          = (state_q == DONE);
  assign bus.unsat_o         = (state_q == DONE) && unsat_q;
  assign bus.bkt_lvl_o       = bkt_lvl_q;
  assign bus.learnt_len_o    = learnt_q;

endmodule

// File: tb/tb_analyze_bkt_ctrl.sv
// Directed bench for analyze_bkt_ctrl; a second instance with a 2-bit length exercises saturation.
module tb_analyze_bkt_ctrl;

  localparam int NV = 8;
  localparam int WL = 10;
  localparam int WC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             start_i = 1'b0;
  logic [NV-1:0]    fc      = 8'h5A;
  logic [NV-1:0]    cl      = '0;
  logic [NV*WL-1:0] lv      = '0;

  analyze_bkt_ctrl_if #(.NUM_VARS(NV), .WIDTH_LVL(WL), .WIDTH_C_LEN(WC)) bus ();
  analyze_bkt_ctrl_if #(.NUM_VARS(NV), .WIDTH_LVL(WL), .WIDTH_C_LEN(2))  bus_s ();

  assign bus.start_i           = start_i;
  assign bus.find_conflict_i   = fc;
  assign bus.clause_len_i      = cl;
  assign bus.max_lvl_i         = lv;
  assign bus_s.start_i         = start_i;
  assign bus_s.find_conflict_i = fc;
  assign bus_s.clause_len_i    = cl;
  assign bus_s.max_lvl_i       = lv;

  analyze_bkt_ctrl #(.NUM_VARS(NV), .WIDTH_LVL(WL), .WIDTH_C_LEN(WC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  analyze_bkt_ctrl #(.NUM_VARS(NV), .WIDTH_LVL(WL), .WIDTH_C_LEN(2)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int r_lat, r_bkt, r_ana, r_stray, r_unsat, r_len, r_lvl, r_len_s;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NV*WL-1:0] lv_set(input logic [NV*WL-1:0] v, input int k, input int l);
    v[k*WL +: WL] = WL'(l);
    return v;
  endfunction

  // Issues one request and follows it to done_o (or a 100-cycle bound, r_lat = -1).
  task automatic run_req(input logic [NV-1:0] flags, input logic [NV*WL-1:0] lvls,
                         input int poke, input int chg_at, input bit toggle);
    int n;
    tick;
    cl = flags;
    lv = lvls;
    r_bkt = 0; r_ana = 0; r_stray = 0; r_lat = -1;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    n = 1;
    while (n < 100) begin
      if (bus.done_o) begin
        r_lat = n;
        break;
      end
      if (bus.apply_bkt_o)     r_bkt++;
      if (bus.apply_analyze_o) r_ana++;
      if (bus.unsat_o)         r_stray++;
      if (toggle || n == chg_at) fc = ~fc;
      start_i = (n == poke);
      tick;
      n++;
    end
    start_i = 1'b0;
    r_unsat = int'(bus.unsat_o);
    r_len   = int'(bus.learnt_len_o);
    r_lvl   = int'(bus.bkt_lvl_o);
    r_len_s = int'(bus_s.learnt_len_o);
  endtask

  logic [NV*WL-1:0] lv_a, lv_b, lv_c, lv_d;

  initial begin
    lv_a = '0;
    lv_a = lv_set(lv_a, 0, 3);
    lv_a = lv_set(lv_a, 1, 3);
    lv_a = lv_set(lv_a, 2, 5);
    lv_a = lv_set(lv_a, 5, 9);
    lv_b = lv_set('0, 6, 4);
    lv_c = '0;
    lv_c = lv_set(lv_c, 0, 7);
    lv_c = lv_set(lv_c, 1, 2);
    lv_c = lv_set(lv_c, 2, 5);
    lv_c = lv_set(lv_c, 3, 5);
    lv_c = lv_set(lv_c, 4, 7);
    lv_d = lv_set('0, 7, 6);

    // Reset state
    tick;
    tick;
    check("rst_analyze", int'(bus.apply_analyze_o), 0);
    check("rst_bkt",     int'(bus.apply_bkt_o), 0);
    check("rst_done",    int'(bus.done_o), 0);
    check("rst_unsat",   int'(bus.unsat_o), 0);
    rst = 1'b1;
    tick;
    check("post_rst_idle", int'(bus.apply_analyze_o), 0);

    // Levels {3,3,5} flagged, unflagged var 5 at level 9 must be ignored
    run_req(8'b0000_0111, lv_a, -1, -1, 1'b0);
    check("s1_latency", r_lat, 12);
    check("s1_ana_cycles", r_ana, 10);
    check("s1_bkt_pulses", r_bkt, 1);
    check("s1_bkt_lvl", r_lvl, 3);
    check("s1_len", r_len, 3);
    check("s1_unsat", r_unsat, 0);
    check("s1_stray_unsat", r_stray, 0);
    tick;
    check("s1_done_one_cycle", int'(bus.done_o), 0);
    tick;
    tick;
    check("s1_lvl_held", int'(bus.bkt_lvl_o), 3);
    check("s1_len_held", int'(bus.learnt_len_o), 3);

    // Single flagged var at level 4
    run_req(8'b0100_0000, lv_b, -1, -1, 1'b0);
    check("s2_latency", r_lat, 12);
    check("s2_bkt_pulses", r_bkt, 1);
    check("s2_bkt_lvl", r_lvl, 0);
    check("s2_len", r_len, 1);

    // No flags: unresolvable, no backtrack strobe
    run_req(8'b0000_0000, lv_a, -1, -1, 1'b0);
    check("s3_latency", r_lat, 11);
    check("s3_unsat", r_unsat, 1);
    check("s3_bkt_pulses", r_bkt, 0);
    tick;
    check("s3_unsat_clears", int'(bus.unsat_o), 0);

    // All flagged levels zero: also unresolvable
    run_req(8'b0011_0000, lv_b, -1, -1, 1'b0);
    check("s4_unsat", r_unsat, 1);
    check("s4_bkt_pulses", r_bkt, 0);

    // {7,2,5,5,7}: repeats of max and second are no-ops; 2-bit length saturates at 3
    run_req(8'b0001_1111, lv_c, -1, -1, 1'b0);
    check("s5_bkt_lvl", r_lvl, 5);
    check("s5_len", r_len, 5);
    check("s5_len_sat", r_len_s, 3);
    check("s5_unsat", r_unsat, 0);

    // Flags change once in ANALYZE: one extra dwell cycle
    run_req(8'b1000_0000, lv_d, -1, 2, 1'b0);
    check("s6_latency", r_lat, 13);
    check("s6_bkt_lvl", r_lvl, 0);
    check("s6_len", r_len, 1);

    // start_i during SCAN and DONE is ignored
    run_req(8'b0000_0111, lv_a, 5, -1, 1'b0);
    check("s7_latency", r_lat, 12);
    check("s7_bkt_pulses", r_bkt, 1);
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    check("s7_done_start_ignored", int'(bus.apply_analyze_o), 0);
    tick;
    check("s7_still_idle", int'(bus.apply_analyze_o), 0);

    // Reset on SCAN cycle 4
    cl = 8'b0000_0111;
    lv = lv_a;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    repeat (5) tick;
    check("s8_in_scan", int'(bus.apply_analyze_o), 1);
    rst = 1'b0;
    tick;
    check("s8_rst_analyze", int'(bus.apply_analyze_o), 0);
    check("s8_rst_bkt", int'(bus.apply_bkt_o), 0);
    check("s8_rst_done", int'(bus.done_o), 0);
    check("s8_rst_lvl", int'(bus.bkt_lvl_o), 0);
    check("s8_rst_len", int'(bus.learnt_len_o), 0);
    rst = 1'b1;
    tick;
    check("s8_idle_after", int'(bus.apply_analyze_o), 0);
    run_req(8'b0000_0111, lv_a, -1, -1, 1'b0);
    check("s8_clean_latency", r_lat, 12);
    check("s8_clean_lvl", r_lvl, 3);
    check("s8_clean_len", r_len, 3);

    // Reset during BKT clears the held results
    tick;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    repeat (10) tick;
    check("s9_in_bkt", int'(bus.apply_bkt_o), 1);
    check("s9_bkt_lvl", int'(bus.bkt_lvl_o), 3);
    rst = 1'b0;
    tick;
    check("s9_rst_bkt", int'(bus.apply_bkt_o), 0);
    check("s9_rst_lvl", int'(bus.bkt_lvl_o), 0);
    check("s9_rst_len", int'(bus.learnt_len_o), 0);
    rst = 1'b1;
    tick;
    check("s9_no_strobe", int'(bus.apply_bkt_o), 0);

    // Flags toggling every cycle
    run_req(8'b0000_0111, lv_a, -1, -1, 1'b1);
`ifdef ANALYZE_TIMEOUT_EN
    check("s10_timeout_latency", r_lat, 26);
    check("s10_timeout_lvl", r_lvl, 3);
`else
    check("s10_no_exit", r_lat, -1);
    check("s10_ana_held", r_ana, 99);
`endif
    rst = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    check("s10_recovered", int'(bus.apply_analyze_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/analyze_bkt_ctrl.md
ANALYZE_BKT_CTRL -- requirements
Module: analyze_bkt_ctrl

Interface
REQ-001 SHALL have parameter NUM_VARS, default 8, meaning the number of var_state1 instances in the bin.
REQ-002 SHALL have parameter WIDTH_LVL, default 10, meaning the decision-level width.
REQ-003 SHALL have parameter WIDTH_C_LEN, default 4, meaning the learnt-clause length width.
REQ-004 SHALL have port clk, input, 1, the clock.
REQ-005 SHALL have port rst, input, 1, a synchronous, active-low reset.
REQ-006 SHALL have port start_i, input, 1, a one-cycle request to resolve the current conflict.
REQ-007 SHALL have port find_conflict_i, input, NUM_VARS, the per-variable value==11 flags.
REQ-008 SHALL have port clause_len_i, input, NUM_VARS, the per-variable learnt-literal flags.
REQ-009 SHALL have port max_lvl_i, input, NUM_VARS*WIDTH_LVL, the per-variable levels (var k at bits [k*WIDTH_LVL +: WIDTH_LVL]).
REQ-010 SHALL have port apply_analyze_o, output, 1, broadcast to all variables during analysis.
REQ-011 SHALL have port apply_bkt_o, output, 1, the one-cycle backtrack strobe.
REQ-012 SHALL have port bkt_lvl_o, output, WIDTH_LVL, the backtrack level.
REQ-013 SHALL have port learnt_len_o, output, WIDTH_C_LEN, the learnt clause length.
REQ-014 SHALL have port done_o, output, 1, the one-cycle completion pulse.
REQ-015 SHALL have port unsat_o, output, 1, high with done_o when the conflict is unresolvable.

Function
REQ-016 SHALL implement FSM states IDLE, ANALYZE, SCAN, BKT and DONE.
REQ-017 IDLE: start_i=1 -> ANALYZE next cycle; start_i in any other state SHALL be ignored.
REQ-018 ANALYZE: apply_analyze_o=1 every cycle; registers find_conflict_i each cycle; leaves for SCAN once the vector equals the previous cycle's value, with a minimum dwell of 2 cycles.
REQ-019 SCAN: index 0..NUM_VARS-1, one variable per cycle, NUM_VARS cycles in total; apply_analyze_o stays 1 so the learnt literals hold.
REQ-020 SCAN, per variable with clause_len_i[k]=1: length increments, saturating at 2^WIDTH_C_LEN-1.
REQ-021 SCAN, per variable with clause_len_i[k]=1: max level is updated, and second level becomes the highest level strictly below max; equal levels do not change second.
REQ-022 End of SCAN: len==0 or max==0 -> DONE with unsat_o=1, and no BKT strobe is issued.
REQ-023 End of SCAN, otherwise -> BKT with bkt_lvl_o = second, which is 0 when len==1.
REQ-024 BKT: apply_bkt_o=1 for exactly one cycle and apply_analyze_o=0; bkt_lvl_o and learnt_len_o are held stable from BKT entry until the next start_i.
REQ-025 DONE: done_o=1 for one cycle, then IDLE; unsat_o is valid only while done_o=1 and is 0 otherwise.
REQ-026 Total latency on the success path SHALL be ANALYZE dwell + NUM_VARS + 2 cycles from start_i to done_o.
REQ-027 A start_i received in DONE SHALL be ignored; the next request is accepted only in IDLE.

Reset
REQ-028 rst=0 SHALL force IDLE and clear every register, so that all outputs are 0, including when rst occurs mid-ANALYZE, mid-SCAN or mid-BKT.
REQ-029 The first cycle after rst deasserts SHALL be IDLE, with no residual strobe.

Configuration
REQ-030 The macro ANALYZE_TIMEOUT_EN SHALL control an ANALYZE watchdog.
REQ-031 With ANALYZE_TIMEOUT_EN defined: ANALYZE exits to SCAN after 2*NUM_VARS cycles even if the flags are still changing.
REQ-032 Without ANALYZE_TIMEOUT_EN: there is no counter, and ANALYZE exits only on stability.

Structure
REQ-033 The package sat_engine_pkg SHALL hold WIDTH_LVL, the WIDTH_C_LEN defaults and the FSM state typedef.
REQ-034 A single sub-module, max2_tracker, SHALL hold the registered max/second-max level update, with clear and enable inputs.

Verification
REQ-035 Scenario: levels {3,3,5} flagged, len 3 -> bkt_lvl_o=3, learnt_len_o=3, one apply_bkt_o pulse, unsat_o=0.
REQ-036 Scenario: single flagged var at level 4 -> bkt_lvl_o=0, learnt_len_o=1.
REQ-037 Scenario: no flags after analysis -> done_o with unsat_o=1 and no apply_bkt_o; same result when all flagged levels are 0.
REQ-038 Scenario: stable flags, NUM_VARS=8 -> done_o exactly 12 cycles after start_i.
REQ-039 Scenario: rst=0 on SCAN cycle 4 -> next cycle all outputs 0; a new start_i runs a clean sequence.
REQ-040 Scenario: ANALYZE_TIMEOUT_EN with flags toggling forever -> SCAN entered after 16 cycles; without the macro the controller stays in ANALYZE.
